laser_point_dac: RTL and testbench

// - Point-output stage for the laser Beta: buffers (x,y,rgb) points in a FIFO and sends

---
 rtl/laser_point_dac.sv | 217 +++++++++++++++++++++
 tb/tb_laser_point_dac.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_point_dac.sv
// Laser point output stage: a FIFO of (x,y,rgb) points drained at a fixed point rate into a
// dual 12-bit SPI galvo DAC (ch A = X, ch B = Y), followed by an LDAC pulse and colour update.
module laser_point_dac #(
    parameter int FIFO_AW      = 4,
    parameter int SCLK_DIV     = 2,
    parameter int POINT_PERIOD = 500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear_flags,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [11:0]        pt_x,
    input  logic [11:0]        pt_y,
    input  logic [2:0]         pt_rgb,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               dac_csn,
    output logic               dac_sclk,
    output logic               dac_mosi,
    output logic               dac_latchn,
    output logic [2:0]         laser_rgb,
    output logic               underflow,
    output logic               overrun
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = (POINT_PERIOD > 1) ? $clog2(POINT_PERIOD) : 1;
    localparam int CW    = $clog2(2 * SCLK_DIV + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POINT_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * SCLK_DIV - 1);

    // state   | meaning
    // IDLE    | waiting for a point tick       LOAD_x  | csn low, load shift word
    // SHIFT_x | 16 SCLK periods of data        GAP_x   | csn high between words
    // LATCH   | LDAC low, colour updated
    typedef enum logic [2:0] {
        IDLE, LOAD_A, SHIFT_A, GAP_A, LOAD_B, SHIFT_B, GAP_B, LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [15:0]     sr_q, sr_d;
    logic [11:0]     x_q, x_d, y_q, y_d;
    logic [2:0]      rgb_q, rgb_d;
    logic            csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d, latchn_q, latchn_d;
    logic [2:0]      laser_q, laser_d;
    logic            uf_q, uf_d, of_q, of_d;
    logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [26:0]     mem_q [DEPTH];
    logic [26:0]     head;
    logic [15:0]     word;
    logic            fifo_empty, fifo_full, push, pop, tick;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                        (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign push       = pt_valid && !fifo_full;
    assign tick       = enable && (timer_q == TIMER_LAST);
    assign head       = mem_q[rd_q[FIFO_AW-1:0]];

    assign pt_ready   = !fifo_full;
    assign fifo_level = wr_q - rd_q;
    assign dac_csn    = csn_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;
    assign dac_latchn = latchn_q;
    assign laser_rgb  = laser_q;
    assign underflow  = uf_q;
    assign overrun    = of_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        x_d      = x_q;
        y_d      = y_q;
        rgb_d    = rgb_q;
        csn_d    = csn_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        latchn_d = latchn_q;
        laser_d  = laser_q;
        uf_d     = clear_flags ? 1'b0 : uf_q;
        of_d     = clear_flags ? 1'b0 : of_q;
        pop      = 1'b0;
        word     = 16'h0000;
        timer_d  = (!enable || timer_q == TIMER_LAST) ? '0 : timer_q + TW'(1);

        if (tick) begin
            if (state_q != IDLE) begin
                of_d = 1'b1;
            end else if (fifo_empty) begin
                uf_d    = 1'b1;
                laser_d = 3'b000;
            end else begin
                pop     = 1'b1;
                x_d     = head[26:15];
                y_d     = head[14:3];
                rgb_d   = head[2:0];
                state_d = LOAD_A;
            end
        end

        case (state_q)
            LOAD_A, LOAD_B: begin
                word    = (state_q == LOAD_A) ? {4'b0011, x_q} : {4'b1011, y_q};
                csn_d   = 1'b0;
                sclk_d  = 1'b0;
                sr_d    = word;
                mosi_d  = word[15];
                cnt_d   = '0;
                bit_d   = 4'd0;
                state_d = (state_q == LOAD_A) ? SHIFT_A : SHIFT_B;
            end
            SHIFT_A, SHIFT_B: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            csn_d   = 1'b1;
                            state_d = (state_q == SHIFT_A) ? GAP_A : GAP_B;
                        end else begin
                            bit_d  = bit_q + 4'd1;
                            sr_d   = {sr_q[14:0], 1'b0};
                            mosi_d = sr_q[14];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP_A, GAP_B: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (state_q == GAP_A) begin
                        state_d = LOAD_B;
                    end else begin
                        latchn_d = 1'b0;
                        laser_d  = rgb_q;
                        state_d  = LATCH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d    = '0;
                    latchn_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase

        // Disabled output forces the laser dark, overriding any latch update.
        if (!enable) laser_d = 3'b000;

        wr_d = wr_q + (FIFO_AW + 1)'(push);
        rd_d = rd_q + (FIFO_AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            sr_q     <= 16'h0000;
            x_q      <= 12'h000;
            y_q      <= 12'h000;
            rgb_q    <= 3'b000;
            csn_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            latchn_q <= 1'b1;
            laser_q  <= 3'b000;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rgb_q    <= rgb_d;
            csn_q    <= csn_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            latchn_q <= latchn_d;
            laser_q  <= laser_d;
            uf_q     <= uf_d;
            of_q     <= of_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[FIFO_AW-1:0]] <= {pt_x, pt_y, pt_rgb};
    end

endmodule

// File: tb/tb_laser_point_dac.sv
// Bench for laser_point_dac: default instance u0 plus a short-period instance u1 for overrun.
module tb_laser_point_dac;

    localparam int SD = 2;
    localparam int PP = 500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst [2], en [2], clr [2], vld [2];
    logic [11:0] px [2], py [2];
    logic [2:0]  pr [2];
    logic        rdy_w [2], csn_w [2], sclk_w [2], mosi_w [2], latchn_w [2], uf_w [2], of_w [2];
    logic [4:0]  lvl_w [2];
    logic [2:0]  lrgb_w [2];

    int n_chk = 0;
    int n_err = 0;

    laser_point_dac u0 (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .clear_flags(clr[0]),
        .pt_valid(vld[0]), .pt_ready(rdy_w[0]), .pt_x(px[0]), .pt_y(py[0]), .pt_rgb(pr[0]),
        .fifo_level(lvl_w[0]), .dac_csn(csn_w[0]), .dac_sclk(sclk_w[0]), .dac_mosi(mosi_w[0]),
        .dac_latchn(latchn_w[0]), .laser_rgb(lrgb_w[0]), .underflow(uf_w[0]), .overrun(of_w[0])
    );

    laser_point_dac #(.POINT_PERIOD(100)) u1 (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .clear_flags(clr[1]),
        .pt_valid(vld[1]), .pt_ready(rdy_w[1]), .pt_x(px[1]), .pt_y(py[1]), .pt_rgb(pr[1]),
        .fifo_level(lvl_w[1]), .dac_csn(csn_w[1]), .dac_sclk(sclk_w[1]), .dac_mosi(mosi_w[1]),
        .dac_latchn(latchn_w[1]), .laser_rgb(lrgb_w[1]), .underflow(uf_w[1]), .overrun(of_w[1])
    );

    // Per-instance scoreboard: expected words/colours pushed at stimulus time, observed
    // words/colours/latch lengths captured from the pins on the falling clock edge.
    for (genvar g = 0; g < 2; g++) begin : mon
        logic [15:0] ew [$];
        logic [2:0]  er [$];
        logic [15:0] ow [$];
        int          ob [$];
        logic [2:0]  orgb [$];
        int          olat [$];
        int          ocs [$];
        int          ofall [$];
        logic [15:0] sh = 16'h0;
        int          nb = 0;
        int          lat_n = 0;
        int          csn_falls = 0;
        logic        csn_p = 1'b1, sclk_p = 1'b0, latchn_p = 1'b1;

        always @(negedge clk) begin
            if (csn_w[g] === 1'b0 && sclk_w[g] === 1'b1 && sclk_p === 1'b0) begin
                sh = {sh[14:0], mosi_w[g]};
                nb++;
            end
            if (csn_w[g] === 1'b1 && csn_p === 1'b0) begin
                ow.push_back(sh);
                ob.push_back(nb);
                nb = 0;
            end
            if (csn_w[g] === 1'b0 && csn_p === 1'b1) begin
                csn_falls++;
                ocs.push_back(cyc);
            end
            if (latchn_w[g] === 1'b0 && latchn_p === 1'b1) begin
                orgb.push_back(lrgb_w[g]);
                ofall.push_back(cyc);
                lat_n = 0;
            end
            if (latchn_w[g] === 1'b0) lat_n++;
            if (latchn_w[g] === 1'b1 && latchn_p === 1'b0) olat.push_back(lat_n);
            csn_p    = csn_w[g];
            sclk_p   = sclk_w[g];
            latchn_p = latchn_w[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    function automatic int npts(input int i);
        return (i == 0) ? mon[0].olat.size() : mon[1].olat.size();
    endfunction

    function automatic int ncf(input int i);
        return (i == 0) ? mon[0].csn_falls : mon[1].csn_falls;
    endfunction

    task automatic wait_pts(input int i, input int n, input int budget);
        int t = 0;
        while (npts(i) < n && t < budget) begin
            step(1);
            t++;
        end
        chk("wait_points", 32'(npts(i) >= n), 32'd1);
    endtask

    task automatic wait_cf(input int i, input int n, input int budget);
        int t = 0;
        while (ncf(i) < n && t < budget) begin
            step(1);
            t++;
        end
        chk("wait_csn_fall", 32'(ncf(i) >= n), 32'd1);
    endtask

    task automatic push(input int i, input logic [11:0] x, input logic [11:0] y,
                        input logic [2:0] c, input logic acc);
        vld[i] = 1'b1;
        px[i]  = x;
        py[i]  = y;
        pr[i]  = c;
        chk("pt_ready", 32'(rdy_w[i]), 32'(acc));
        if (acc) begin
            if (i == 0) begin
                mon[0].ew.push_back({4'b0011, x});
                mon[0].ew.push_back({4'b1011, y});
                mon[0].er.push_back(c);
            end else begin
                mon[1].ew.push_back({4'b0011, x});
                mon[1].ew.push_back({4'b1011, y});
                mon[1].er.push_back(c);
            end
        end
        step(1);
        vld[i] = 1'b0;
    endtask

    task automatic check_point(input int i);
        logic [15:0] ew0, ew1, ow0, ow1;
        logic [2:0]  er, orr;
        int          b0, b1, lat;
        if (i == 0) begin
            ew0 = mon[0].ew.pop_front();  ew1 = mon[0].ew.pop_front();
            ow0 = mon[0].ow.pop_front();  ow1 = mon[0].ow.pop_front();
            b0  = mon[0].ob.pop_front();  b1  = mon[0].ob.pop_front();
            er  = mon[0].er.pop_front();  orr = mon[0].orgb.pop_front();
            lat = mon[0].olat.pop_front();
        end else begin
            ew0 = mon[1].ew.pop_front();  ew1 = mon[1].ew.pop_front();
            ow0 = mon[1].ow.pop_front();  ow1 = mon[1].ow.pop_front();
            b0  = mon[1].ob.pop_front();  b1  = mon[1].ob.pop_front();
            er  = mon[1].er.pop_front();  orr = mon[1].orgb.pop_front();
            lat = mon[1].olat.pop_front();
        end
        chk("word_a", 32'(ow0), 32'(ew0));
        chk("bits_a", 32'(b0), 32'd16);
        chk("word_b", 32'(ow1), 32'(ew1));
        chk("bits_b", 32'(b1), 32'd16);
        chk("latch_rgb", 32'(orr), 32'(er));
        chk("latch_len", 32'(lat), 32'(2 * SD));
    endtask

    initial begin
        int e, cf;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; clr[i] = 1'b0; vld[i] = 1'b0;
            px[i] = 12'h0; py[i] = 12'h0; pr[i] = 3'b0;
        end
        step(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        chk("rst_csn", 32'(csn_w[0]), 32'd1);
        chk("rst_sclk", 32'(sclk_w[0]), 32'd0);
        chk("rst_mosi", 32'(mosi_w[0]), 32'd0);
        chk("rst_latchn", 32'(latchn_w[0]), 32'd1);
        chk("rst_rgb", 32'(lrgb_w[0]), 32'd0);
        chk("rst_level", 32'(lvl_w[0]), 32'd0);
        chk("rst_underflow", 32'(uf_w[0]), 32'd0);
        chk("rst_overrun", 32'(of_w[0]), 32'd0);

        // Single point: tick timing, word content, latch width and colour
        push(0, 12'h123, 12'hABC, 3'b101, 1'b1);
        chk("level_one", 32'(lvl_w[0]), 32'd1);
        en[0] = 1'b1;
        e = cyc;
        wait_pts(0, 1, 800);
        chk("csn_fall_cycle", 32'(mon[0].ocs.pop_front() - e), 32'(PP + 1));
        chk("latch_cycle", 32'(mon[0].ofall.pop_front() - e), 32'((PP - 1) + 1 + 2 * (1 + 33 * SD)));
        check_point(0);
        chk("rgb_after_latch", 32'(lrgb_w[0]), 32'd5);

        // Next tick finds the FIFO empty
        wait_until(e + 2 * PP - 1);
        chk("uf_before_tick", 32'(uf_w[0]), 32'd0);
        chk("rgb_before_tick", 32'(lrgb_w[0]), 32'd5);
        step(1);
        chk("uf_after_tick", 32'(uf_w[0]), 32'd1);
        chk("rgb_after_uf", 32'(lrgb_w[0]), 32'd0);
        chk("no_csn_on_uf", 32'(mon[0].csn_falls), 32'd2);
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        chk("uf_cleared", 32'(uf_w[0]), 32'd0);
        chk("of_clear", 32'(of_w[0]), 32'd0);
        en[0] = 1'b0;

        // Short point period: ticks land mid-transfer
        push(1, 12'h001, 12'hFFF, 3'b001, 1'b1);
        push(1, 12'hFFF, 12'h000, 3'b010, 1'b1);
        push(1, 12'hA5A, 12'h5A5, 3'b111, 1'b1);
        push(1, 12'h800, 12'h7FF, 3'b100, 1'b1);
        en[1] = 1'b1;
        wait_pts(1, 4, 2500);
        for (int k = 0; k < 4; k++) check_point(1);
        chk("overrun_set", 32'(of_w[1]), 32'd1);
        chk("u1_level", 32'(lvl_w[1]), 32'd0);
        en[1] = 1'b0;

        // Fill to full while disabled, drop an extra, then drain in order
        for (int k = 0; k < 16; k++)
            push(0, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 3'(k), 1'b1);
        chk("full_level", 32'(lvl_w[0]), 32'd16);
        push(0, 12'hEEE, 12'h111, 3'b011, 1'b0);
        chk("drop_level", 32'(lvl_w[0]), 32'd16);
        en[0] = 1'b1;
        e = cyc;
        wait_until(e + 13 * PP + PP - 1);
        chk("level_three", 32'(lvl_w[0]), 32'd3);
        push(0, 12'h3C3, 12'hC3C, 3'b110, 1'b1);
        chk("push_pop_level", 32'(lvl_w[0]), 32'd3);
        wait_pts(0, 17, 2000);
        for (int k = 0; k < 17; k++) check_point(0);
        en[0] = 1'b0;

        // Second fill: write pointer wraps past the pointer modulus
        for (int k = 0; k < 16; k++)
            push(0, 12'(k * 12'h101), 12'(12'hFFF - k), 3'(k + 1), 1'b1);
        chk("wrap_full_level", 32'(lvl_w[0]), 32'd16);
        chk("wrap_ready", 32'(rdy_w[0]), 32'd0);
        en[0] = 1'b1;
        wait_pts(0, 1, 800);
        check_point(0);
        chk("wrap_rgb", 32'(lrgb_w[0]), 32'd1);

        // Disable mid-transfer: transfer completes, laser dark, latch leaves it dark
        cf = mon[0].csn_falls;
        wait_cf(0, cf + 1, 700);
        step(3);
        en[0] = 1'b0;
        step(1);
        chk("rgb_disable", 32'(lrgb_w[0]), 32'd0);
        mon[0].er[0] = 3'b000;
        wait_pts(0, 1, 300);
        check_point(0);
        chk("rgb_held_dark", 32'(lrgb_w[0]), 32'd0);

        // Reset in the middle of SHIFT_B
        en[0] = 1'b1;
        cf = mon[0].csn_falls;
        wait_cf(0, cf + 2, 800);
        step(10);
        repeat (4) if (sclk_w[0] !== 1'b1) step(1);
        chk("sclk_before_reset", 32'(sclk_w[0]), 32'd1);
        rst[0] = 1'b1;
        step(1);
        chk("mid_rst_csn", 32'(csn_w[0]), 32'd1);
        chk("mid_rst_sclk", 32'(sclk_w[0]), 32'd0);
        chk("mid_rst_mosi", 32'(mosi_w[0]), 32'd0);
        chk("mid_rst_latchn", 32'(latchn_w[0]), 32'd1);
        chk("mid_rst_rgb", 32'(lrgb_w[0]), 32'd0);
        chk("mid_rst_level", 32'(lvl_w[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy_w[0]), 32'd1);
        rst[0] = 1'b0;
        en[0]  = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
